// File: rtl/fib_timer_buffer.sv
// Circular FIFO between the Fibonacci/Timer producers and the 7-segment consumer.
// Optional sticky overflow flag is compiled in when FIB_BUFFER_OVF_EN is defined.
module fib_timer_buffer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       data_in_valid,
   input  logic                       consume_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_out_valid,
   output logic                       buffer_full,
   output logic                       buffer_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [CW-1:0]    count_nxt;
   logic             wr_ok;
   logic             rd_ok;

   // A write into a full buffer is allowed when the same-cycle pop frees a slot.
   assign wr_ok = data_in_valid & (~buffer_full | consume_en);
   assign rd_ok = consume_en & ~buffer_empty;

   always_comb begin
      count_nxt = count;
      if (wr_ok && !rd_ok)
         count_nxt = count + 1'b1;
      else if (!wr_ok && rd_ok)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst && wr_ok)
         mem[wp] <= data_in;
   end

   // Flags derive from the next count so they change on the same edge as count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wp             <= '0;
         rp             <= '0;
         count          <= '0;
         buffer_full    <= 1'b0;
         buffer_empty   <= 1'b1;
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         count          <= count_nxt;
         buffer_full    <= (count_nxt == CW'(DEPTH));
         buffer_empty   <= (count_nxt == '0);
         data_out_valid <= rd_ok;
         if (wr_ok)
            wp <= wp + 1'b1;
         if (rd_ok) begin
            data_out <= mem[rp];
            rp       <= rp + 1'b1;
         end
      end
   end

`ifdef FIB_BUFFER_OVF_EN
   always_ff @(posedge clk) begin
      if (!rst)
         overflow <= 1'b0;
      else if (data_in_valid && buffer_full && !consume_en)
         overflow <= 1'b1;
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fib_timer_buffer.sv
// Self-checking bench for fib_timer_buffer: directed plan steps, then random traffic
// compared against a queue-based reference model.
module tb_fib_timer_buffer;

   localparam int DEPTH = 8;
   localparam int WIDTH = 16;
   localparam int CW    = $clog2(DEPTH+1);
`ifdef FIB_BUFFER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             data_in_valid = 1'b0;
   logic             consume_en = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             data_out_valid;
   logic             buffer_full;
   logic             buffer_empty;
   logic [CW-1:0]    count;
   logic             overflow;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout = '0;
   logic             m_dv   = 1'b0;
   logic             m_ovf  = 1'b0;

   fib_timer_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .consume_en     (consume_en),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .buffer_full    (buffer_full),
      .buffer_empty   (buffer_empty),
      .count          (count),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   function automatic void model_edge(logic r, logic v, logic [WIDTH-1:0] d, logic c);
      int unsigned n;
      logic        full, empty, rd, wr;
      if (!r) begin
         q.delete();
         m_dout = '0;
         m_dv   = 1'b0;
         m_ovf  = 1'b0;
         return;
      end
      n     = q.size();
      full  = (n == DEPTH);
      empty = (n == 0);
      rd    = c && !empty;
      wr    = v && (!full || c);
      if (OVF_EN && v && full && !c) m_ovf = 1'b1;
      m_dv = rd;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(d);
   endfunction

   task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic c);
      rst           = r;
      data_in_valid = v;
      data_in       = d;
      consume_en    = c;
      @(posedge clk);
      model_edge(r, v, d, c);
      #1;
      check("data_out",       32'(data_out),       32'(m_dout));
      check("data_out_valid", 32'(data_out_valid), 32'(m_dv));
      check("count",          32'(count),          32'(q.size()));
      check("buffer_full",    32'(buffer_full),    32'(q.size() == DEPTH));
      check("buffer_empty",   32'(buffer_empty),   32'(q.size() == 0));
      check("overflow",       32'(overflow),       32'(m_ovf));
   endtask

   initial begin
      // reset
      step(1'b0, 1'b0, '0, 1'b0);
      check("reset_count", 32'(count), 0);
      check("reset_empty", 32'(buffer_empty), 1);

      // fill with 1..8
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, WIDTH'(i), 1'b0);
      check("fill_count", 32'(count), DEPTH);
      check("fill_full",  32'(buffer_full), 1);
      check("fill_empty", 32'(buffer_empty), 0);

      // drain with single-cycle pulses
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 1'b0, '0, 1'b1);
         check("drain_data", 32'(data_out), i);
         check("drain_dv",   32'(data_out_valid), 1);
         step(1'b1, 1'b0, '0, 1'b0);
         check("drain_dv_pulse", 32'(data_out_valid), 0);
         check("drain_hold",     32'(data_out), i);
      end
      check("drain_empty", 32'(buffer_empty), 1);

      // full + simultaneous write/pop, then drain across the wrap
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, WIDTH'(i), 1'b0);
      step(1'b1, 1'b1, 16'h00AA, 1'b1);
      check("fullrw_data",  32'(data_out), 32'h0001);
      check("fullrw_count", 32'(count), DEPTH);
      for (int i = 2; i <= DEPTH + 1; i++) begin
         step(1'b1, 1'b0, '0, 1'b1);
         check("wrap_data", 32'(data_out), (i <= DEPTH) ? i : 32'h00AA);
      end
      check("wrap_empty", 32'(buffer_empty), 1);

      // empty + simultaneous write/pop: no bypass
      step(1'b1, 1'b1, 16'h0055, 1'b1);
      check("emptyrw_dv",    32'(data_out_valid), 0);
      check("emptyrw_count", 32'(count), 1);
      step(1'b1, 1'b0, '0, 1'b1);
      check("emptyrw_pop", 32'(data_out), 32'h0055);

      // write while full is dropped
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, WIDTH'(16'h0100 + i), 1'b0);
      step(1'b1, 1'b1, 16'h1234, 1'b0);
      check("ovf_flag",  32'(overflow), OVF_EN ? 1 : 0);
      check("ovf_count", 32'(count), DEPTH);
      step(1'b1, 1'b0, '0, 1'b0);
      check("ovf_sticky", 32'(overflow), OVF_EN ? 1 : 0);
      step(1'b1, 1'b0, '0, 1'b1);
      check("ovf_data_kept", 32'(data_out), 32'h0101);
      step(1'b0, 1'b1, 16'hFFFF, 1'b1);
      check("rst_ovf",   32'(overflow), 0);
      check("rst_count", 32'(count), 0);
      check("rst_dout",  32'(data_out), 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic r, v, c;
         r = ($urandom_range(0, 63) != 0);
         v = ($urandom_range(0, 99) < 55);
         c = ($urandom_range(0, 99) < 45);
         step(r, v, WIDTH'($urandom), c);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
